key_bounce_gen: RTL and testbench
=================================

// Module: key_bounce_gen
// PURPOSE
//  Synthesizable mechanical-key emulator: accepts press/release commands and drives a
//  key line with pseudo-random contact bounce, then a stable level. It is the driving
//  end of the key debounce path (feeds key_in of key_filter) for on-board self-test of
//  the UI keys without touching a physical button. Key line is active-low (0 = pressed).
// PARAMETERS
//  BOUNCE_CYCLES  500_000  total bounce window in Clk cycles (10 ms @ 50 MHz), >=2
//  GLITCH_W       8        width of LFSR slice setting each bounce segment: 1..2^GLITCH_W cycles
//  HOLD_CYCLES    1_500_000 stable-level hold after bounce before done (30 ms @ 50 MHz), >=1
//  LFSR_SEED      16'hACE1 LFSR reset value; 0 is illegal and replaced by 16'hACE1
// PORTS
//  Clk        in   1  system clock, 50 MHz
//  Rst_n      in   1  asynchronous active-low reset
//  cmd_valid  in   1  command request
//  cmd_press  in   1  command target: 1 = press (key_out->0), 0 = release (key_out->1)
//  cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready
//  key_out    out  1  emulated key line, active-low
//  busy       out  1  high in BOUNCE and SETTLE
//  done       out  1  one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset: key_out=1, cmd_ready=1, busy=0, done=0, state=IDLE, LFSR=LFSR_SEED, counters=0.
//  Reset mid-operation aborts immediately; no done pulse; next command starts from IDLE.
//  FSM: IDLE -> BOUNCE -> SETTLE -> DONE -> IDLE.
//   IDLE: cmd_ready=1. On accept (cycle 0), target T = ~cmd_press latched.
//    - T == key_out (same-level command): go straight to DONE; done at cycle 1, key_out unchanged.
//    - else: go to BOUNCE; key_out <= T at cycle 1 (first edge).
//   BOUNCE: bounce counter runs BOUNCE_CYCLES cycles (cycles 1..BOUNCE_CYCLES).
//    - segment counter loaded with lfsr[GLITCH_W-1:0]+1; on expiry key_out toggles,
//      LFSR advances one step, segment reloads.
//    - segment expiry coinciding with bounce end: bounce end wins, no toggle.
//    - last BOUNCE cycle: key_out forced to T regardless of toggle parity.
//   SETTLE: key_out held at T for HOLD_CYCLES cycles; no toggles.
//   DONE: done=1 for exactly one cycle, busy=0, cmd_ready=0; then IDLE.
//  Latency (level-changing command): first edge cycle 1; stable from cycle BOUNCE_CYCLES+1;
//   done at cycle BOUNCE_CYCLES+HOLD_CYCLES+1; cmd_ready returns cycle after done.
//  cmd_valid while not ready is ignored (no queueing); cmd_press sampled only on accept.
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances only on a segment toggle;
//   never reaches 0. GLITCH_W must be <= 16.
//  Counters sized $clog2 of their parameter+1; no wrap within a command.
//  Outputs are registered; no combinational path from cmd_* to key_out.
// TESTING  (BOUNCE_CYCLES=100, GLITCH_W=3, HOLD_CYCLES=50, LFSR_SEED=16'hACE1)
//  Reset release, no command -> key_out=1, cmd_ready=1, busy=0, done=0 indefinitely.
//  Press cmd at cycle 0 -> key_out=0 at cycle 1; every segment 1..8 cycles; key_out=0
//   from cycle 101 through done; done pulse exactly at cycle 151; busy high cycles 1..150.
//  Press then release -> mirror behaviour ending key_out=1; key_filter fed by key_out
//   asserts exactly one press flag and one release flag.
//  Release cmd while already released -> key_out stays 1, no toggles, done at cycle 1.
//  cmd_valid pulsed at cycles 20 and 120 during a press -> both ignored, cmd_ready=0, one done.
//  Rst_n low at cycle 60 of BOUNCE -> key_out=1 immediately, no done; re-issued press
//   reproduces the identical toggle sequence (LFSR reseeded).

Source files
------------

// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: press/release commands drive an active-low key line
// through an LFSR-timed bounce window, a stable hold period and a done pulse.
module key_bounce_gen #(
  parameter int unsigned BOUNCE_CYCLES = 500_000,
  parameter int unsigned GLITCH_W      = 8,
  parameter int unsigned HOLD_CYCLES   = 1_500_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic cmd_valid,
  input  logic cmd_press,
  output logic cmd_ready,
  output logic key_out,
  output logic busy,
  output logic done
);

  localparam int unsigned BCNT_W = $clog2(BOUNCE_CYCLES + 1);
  localparam int unsigned HCNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned SEG_W  = GLITCH_W + 1;
  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0] TAPS   = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BOUNCE = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                target, target_nxt;
  logic [BCNT_W-1:0]   bcnt, bcnt_nxt;
  logic [HCNT_W-1:0]   hcnt, hcnt_nxt;
  logic [SEG_W-1:0]    seg, seg_nxt;
  logic [15:0]         lfsr, lfsr_nxt, lfsr_adv;
  logic                key_nxt, busy_nxt, done_nxt, ready_nxt;
  logic                tgt_c;

  // Segment length is the low LFSR slice plus one, so it never reads as zero
  function automatic logic [SEG_W-1:0] seg_len(input logic [15:0] l);
    return SEG_W'(l[GLITCH_W-1:0]) + SEG_W'(1);
  endfunction

  // One Galois LFSR step; a nonzero state never maps to zero
  always_comb begin
    lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
  end

  // Target level for an incoming command (active-low line)
  always_comb begin
    tgt_c = ~cmd_press;
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    bcnt_nxt   = bcnt;
    hcnt_nxt   = hcnt;
    seg_nxt    = seg;
    lfsr_nxt   = lfsr;
    key_nxt    = key_out;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    ready_nxt  = cmd_ready;

    unique case (state)
      S_IDLE: begin
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        if (cmd_valid && cmd_ready) begin
          target_nxt = tgt_c;
          ready_nxt  = 1'b0;
          if (tgt_c == key_out) begin
            // Line already at the requested level: complete without bouncing
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_BOUNCE;
            busy_nxt  = 1'b1;
            key_nxt   = tgt_c;
            bcnt_nxt  = BCNT_W'(BOUNCE_CYCLES - 1);
            seg_nxt   = seg_len(lfsr);
          end
        end
      end

      S_BOUNCE: begin
        if (bcnt == '0) begin
          // Last bounce cycle wins over any segment expiry and lands on target
          state_nxt = S_SETTLE;
          key_nxt   = target;
          hcnt_nxt  = HCNT_W'(HOLD_CYCLES - 1);
        end else begin
          bcnt_nxt = bcnt - BCNT_W'(1);
          if (seg == SEG_W'(1)) begin
            key_nxt  = ~key_out;
            lfsr_nxt = lfsr_adv;
            seg_nxt  = seg_len(lfsr_adv);
          end else begin
            seg_nxt = seg - SEG_W'(1);
          end
        end
      end

      S_SETTLE: begin
        if (hcnt == '0) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          hcnt_nxt = hcnt - HCNT_W'(1);
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      target    <= 1'b1;
      bcnt      <= '0;
      hcnt      <= '0;
      seg       <= '0;
      lfsr      <= SEED;
      key_out   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      bcnt      <= bcnt_nxt;
      hcnt      <= hcnt_nxt;
      seg       <= seg_nxt;
      lfsr      <= lfsr_nxt;
      key_out   <= key_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cmd_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Bench for key_bounce_gen: random press/release commands checked cycle by
// cycle against a waveform predicted from the segment/LFSR rules.
module tb_key_bounce_gen;

  localparam int unsigned B  = 100;
  localparam int unsigned GW = 3;
  localparam int unsigned H  = 50;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int unsigned FILT_N = 20;

  logic Clk, Rst_n, cmd_valid, cmd_press;
  logic cmd_ready, key_out, busy, done;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_lfsr;
  logic        m_key;
  logic        wave [0:B];

  int  f_run = 0;
  logic f_last = 1'b1;
  logic f_filt = 1'b1;
  int  press_flags = 0;
  int  release_flags = 0;

  key_bounce_gen #(
    .BOUNCE_CYCLES(B),
    .GLITCH_W(GW),
    .HOLD_CYCLES(H),
    .LFSR_SEED(SEED)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .cmd_valid(cmd_valid),
    .cmd_press(cmd_press),
    .cmd_ready(cmd_ready),
    .key_out(key_out),
    .busy(busy),
    .done(done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Simple downstream debouncer: a level counts once it is stable FILT_N cycles
  always @(posedge Clk) begin
    if (key_out == f_last) begin
      if (f_run < 1000) f_run = f_run + 1;
    end else begin
      f_run = 1;
    end
    f_last = key_out;
    if (f_run == FILT_N && key_out != f_filt) begin
      f_filt = key_out;
      if (key_out == 1'b0) press_flags = press_flags + 1;
      else release_flags = release_flags + 1;
    end
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input int cyc, input logic ek, input logic eb, input logic ed, input logic er);
    chk("key_out", cyc, key_out, ek);
    chk("busy", cyc, busy, eb);
    chk("done", cyc, done, ed);
    chk("cmd_ready", cyc, cmd_ready, er);
  endtask

  // Predict the bounce window: a list of segments, each (slice+1) long,
  // toggling between segments unless the boundary falls past the window end.
  task automatic build_wave(input logic t);
    logic lvl;
    int   pos, seg;
    lvl = t;
    pos = 1;
    seg = int'(m_lfsr & 16'((1 << GW) - 1)) + 1;
    forever begin
      for (int c = pos; c < pos + seg && c <= int'(B); c++) wave[c] = lvl;
      if (pos + seg <= int'(B)) begin
        lvl    = ~lvl;
        m_lfsr = lfsr_step(m_lfsr);
        pos    = pos + seg;
        seg    = int'(m_lfsr & 16'((1 << GW) - 1)) + 1;
      end else begin
        break;
      end
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED;
    m_key  = 1'b1;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge Clk);
      chk_all(-1, m_key, 1'b0, 1'b0, 1'b1);
      @(posedge Clk); #1;
    end
  endtask

  // Entered and left just after a rising edge. Cycle 0 presents the command.
  task automatic run_cmd(input logic press, input int n1, input int n2, input int abort_k);
    logic t, same, ek, eb, ed, er;
    int   n;
    t    = ~press;
    same = (t == m_key);
    if (!same) build_wave(t);
    n = same ? 2 : int'(B + H + 2);
    for (int k = 0; k <= n; k++) begin
      cmd_valid = (k == 0) || ((k == n1 || k == n2) && k < n);
      cmd_press = (k == 0) ? press : 1'($urandom);
      if (abort_k > 0 && k == abort_k) begin
        cmd_valid = 1'b0;
        Rst_n = 1'b0;
        #1;
        chk_all(k, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge Clk); #1;
        chk_all(k + 1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        model_reset();
        return;
      end
      @(negedge Clk);
      if (k == 0) begin
        ek = m_key; eb = 1'b0; ed = 1'b0; er = 1'b1;
      end else if (same) begin
        ek = m_key; eb = 1'b0; ed = (k == 1); er = (k == 2);
      end else if (k <= int'(B)) begin
        ek = wave[k]; eb = 1'b1; ed = 1'b0; er = 1'b0;
      end else if (k <= int'(B + H)) begin
        ek = t; eb = 1'b1; ed = 1'b0; er = 1'b0;
      end else if (k == int'(B + H + 1)) begin
        ek = t; eb = 1'b0; ed = 1'b1; er = 1'b0;
      end else begin
        ek = t; eb = 1'b0; ed = 1'b0; er = 1'b1;
      end
      chk_all(k, ek, eb, ed, er);
      @(posedge Clk); #1;
    end
    cmd_valid = 1'b0;
    if (!same) m_key = t;
  endtask

  initial begin
    int p0, r0;
    Rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_press = 1'b0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    // Idle after reset
    idle(12);

    // Press with ignored requests at 20 and 120, then release
    p0 = press_flags;
    r0 = release_flags;
    run_cmd(1'b1, 20, 120, 0);
    idle(3);
    run_cmd(1'b0, -1, -1, 0);
    idle(25);
    chk_int("press_flags", press_flags - p0, 1);
    chk_int("release_flags", release_flags - r0, 1);

    // Same-level commands
    run_cmd(1'b0, 1, -1, 0);
    run_cmd(1'b1, -1, -1, 0);
    run_cmd(1'b1, 1, -1, 0);
    run_cmd(1'b0, -1, -1, 0);

    // Randomised command stream
    for (int i = 0; i < 10; i++) begin
      run_cmd(1'($urandom), int'($urandom_range(1, 160)), int'($urandom_range(1, 160)), 0);
      idle(int'($urandom_range(0, 4)));
    end
    if (m_key == 1'b0) run_cmd(1'b0, -1, -1, 0);

    // Reset during bounce, then the reseeded press replays from the seed
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    model_reset();
    idle(2);
    run_cmd(1'b1, -1, -1, 60);
    idle(3);
    run_cmd(1'b1, 30, -1, 0);
    run_cmd(1'b0, -1, -1, 0);
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
